div_arb: RTL

Round-robin arbiter and sequencer that shares one multi-cycle divider unit (signed/unsigned div/mod, valid/ready issue side, one-cycle `done` pulse on completion) between two requesters, e.g. the EX stage and a secondary issue port. It sits between the requesters and the divider. It owns the single outstanding divide, routes the result back to the requester that issued it, and discards results for requests flushed while in flight. Only one divide is outstanding at any time.

---
 rtl/div_arb.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/div_arb.sv
// div_arb -- round-robin arbiter and sequencer sharing one multi-cycle divider
// between two requesters.
//
// The arbiter owns the single outstanding divide. It latches the winning
// request, issues it to the divider with a valid/ready handshake, waits for
// the completion pulse and returns the result to the requester that issued
// it. Results of requests flushed while in flight are dropped.
//
// Parameters:
//   DATA_W  operand/result width
//   OP_W    op code width (00 div.s, 01 mod.s, 10 div.u, 11 mod.u)
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   rN_valid/rN_ready                  request handshake, N in {0,1}
//   rN_op, rN_src1, rN_src2            op code, dividend, divisor
//   rN_flush                           cancel requester N's pending/in-flight op
//   rN_rvalid/rN_rready, rN_rdata      result handshake and data
//   d_valid/d_ready                    issue handshake towards the divider
//   d_op, d_src1, d_src2               latched operation and operands
//   d_done, d_result                   divider completion pulse and result
//   busy                               high whenever the FSM is not idle
//
// Optional feature: define DIV_ARB_ZERO_BYPASS_EN to answer zero-divisor
// requests locally (div -> all ones, mod -> dividend) without the divider.

module div_arb #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_op,
    input  logic [DATA_W-1:0] r0_src1,
    input  logic [DATA_W-1:0] r0_src2,
    input  logic              r0_flush,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_op,
    input  logic [DATA_W-1:0] r1_src1,
    input  logic [DATA_W-1:0] r1_src2,
    input  logic              r1_flush,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              d_valid,
    input  logic              d_ready,
    output logic [OP_W-1:0]   d_op,
    output logic [DATA_W-1:0] d_src1,
    output logic [DATA_W-1:0] d_src2,
    input  logic              d_done,
    input  logic [DATA_W-1:0] d_result,

    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_reg;
    logic                owner_reg;
    logic                rr_last_reg;
    logic                discard_reg;
    logic [OP_W-1:0]     op_reg;
    logic [DATA_W-1:0]   src1_reg;
    logic [DATA_W-1:0]   src2_reg;
    logic [DATA_W-1:0]   result_reg;

    // Requester-indexed views of the two ports.
    logic [1:0]          req_valid;
    logic [1:0]          req_flush;
    logic [1:0]          req_rready;
    logic [OP_W-1:0]     req_op   [2];
    logic [DATA_W-1:0]   req_src1 [2];
    logic [DATA_W-1:0]   req_src2 [2];

    logic [1:0]          qual;
    logic [1:0]          grant;
    logic [1:0]          rvalid;
    logic                idle;
    logic                accept;
    logic                winner;
    logic                owner_flush;
    logic                owner_rready;
    logic                bypass;
    logic [DATA_W-1:0]   bypass_result;

    assign req_valid   = {r1_valid, r0_valid};
    assign req_flush   = {r1_flush, r0_flush};
    assign req_rready  = {r1_rready, r0_rready};
    assign req_op[0]   = r0_op;
    assign req_op[1]   = r1_op;
    assign req_src1[0] = r0_src1;
    assign req_src1[1] = r1_src1;
    assign req_src2[0] = r0_src2;
    assign req_src2[1] = r1_src2;

    assign idle = (state_reg == S_IDLE);

    // A flushing requester never competes. On a tie the requester that was
    // not granted last time wins.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign qual[gi]   = req_valid[gi] & ~req_flush[gi];
            assign grant[gi]  = idle & qual[gi] &
                                (~qual[1-gi] | (rr_last_reg == 1'(1-gi)));
            assign rvalid[gi] = (state_reg == S_RESP) & (owner_reg == 1'(gi));
        end
    endgenerate

    assign accept       = |grant;
    assign winner       = grant[1];
    assign owner_flush  = req_flush[owner_reg];
    assign owner_rready = req_rready[owner_reg];

`ifdef DIV_ARB_ZERO_BYPASS_EN
    assign bypass        = (req_src2[winner] == '0);
    assign bypass_result = req_op[winner][0] ? req_src1[winner] : '1;
`else
    assign bypass        = 1'b0;
    assign bypass_result = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            owner_reg   <= 1'b0;
            rr_last_reg <= 1'b1;
            discard_reg <= 1'b0;
            op_reg      <= '0;
            src1_reg    <= '0;
            src2_reg    <= '0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        op_reg      <= req_op[winner];
                        src1_reg    <= req_src1[winner];
                        src2_reg    <= req_src2[winner];
                        owner_reg   <= winner;
                        rr_last_reg <= winner;
                        discard_reg <= 1'b0;
                        if (bypass) begin
                            result_reg <= bypass_result;
                            state_reg  <= S_RESP;
                        end else begin
                            state_reg  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // The issue is never withdrawn; a flush only marks the
                    // eventual result for dropping.
                    if (owner_flush) discard_reg <= 1'b1;
                    if (d_ready)     state_reg   <= S_WAIT;
                end
                S_WAIT: begin
                    if (owner_flush) discard_reg <= 1'b1;
                    if (d_done) begin
                        result_reg <= d_result;
                        state_reg  <= (discard_reg | owner_flush) ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (owner_flush | owner_rready) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign r0_ready  = grant[0];
    assign r1_ready  = grant[1];
    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];
    assign r0_rdata  = result_reg;
    assign r1_rdata  = result_reg;
    assign d_valid   = (state_reg == S_ISSUE);
    assign d_op      = op_reg;
    assign d_src1    = src1_reg;
    assign d_src2    = src2_reg;
    assign busy      = ~idle;

endmodule
